// File: rtl/core_alu_reg_if.sv
// Operand/flag bus between the CPU core and the ALU with its registered output stage.
// The master drives operands and control; the slave returns combinational and registered results.
interface core_alu_reg_if;
    logic       I_enable;
    logic [3:0] I_control;
    logic [3:0] I_mask_p;
    logic [7:0] I_lhs;
    logic [7:0] I_rhs;
    logic       I_carry;
    logic       I_overflow;
    logic       I_sign;
    logic       I_zero;
    logic [7:0] O_result;
    logic       O_carry;
    logic       O_overflow;
    logic       O_sign;
    logic       O_zero;
    logic [7:0] Q_result;
    logic [3:0] Q_flags;

    modport master (
        output I_enable, I_control, I_mask_p, I_lhs, I_rhs,
        output I_carry, I_overflow, I_sign, I_zero,
        input  O_result, O_carry, O_overflow, O_sign, O_zero,
        input  Q_result, Q_flags
    );

    modport slave (
        input  I_enable, I_control, I_mask_p, I_lhs, I_rhs,
        input  I_carry, I_overflow, I_sign, I_zero,
        output O_result, O_carry, O_overflow, O_sign, O_zero,
        output Q_result, Q_flags
    );
endinterface

// File: rtl/core_alu_reg.sv
// 8-bit 2A03 ALU (no decimal mode) with a clock-enabled result/flag register bank.
// Combinational outputs are zero-latency; Q_* capture them on enabled rising edges.
module core_alu_reg #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input logic           I_clock,
    input logic           I_reset,
    core_alu_reg_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLAG_W = 4;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SBC = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_ORA = 4'd4;
    localparam logic [3:0] OP_EOR = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_BIT = 4'd7;
    localparam logic [3:0] OP_ASL = 4'd8;
    localparam logic [3:0] OP_LSR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_INC = 4'd12;
    localparam logic [3:0] OP_DEC = 4'd13;
    localparam logic [3:0] OP_LD  = 4'd14;

    // Flag-select bit positions, shared by w_touch, I_mask_p and Q_flags ordering {N,V,Z,C}
    localparam int unsigned F_C = 0;
    localparam int unsigned F_Z = 1;
    localparam int unsigned F_V = 2;
    localparam int unsigned F_N = 3;

    logic [DATA_W:0]   w_add;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic              w_n;
    logic              w_z;
    logic [FLAG_W-1:0] w_touch;
    logic [FLAG_W-1:0] w_upd;
    logic [FLAG_W-1:0] w_flags;

    logic [DATA_W-1:0] r_result;
    logic [FLAG_W-1:0] r_flags;

    // Datapath: w_touch marks which flags the selected operation defines
    always_comb begin
        w_add   = '0;
        w_res   = bus.I_lhs;
        w_c     = bus.I_carry;
        w_v     = bus.I_overflow;
        w_touch = '0;
        case (bus.I_control)
            OP_ADC: begin
                w_add   = {1'b0, bus.I_lhs} + {1'b0, bus.I_rhs} + (DATA_W+1)'(bus.I_carry);
                w_res   = w_add[DATA_W-1:0];
                w_c     = w_add[DATA_W];
                w_v     = ~(bus.I_lhs[7] ^ bus.I_rhs[7]) & (bus.I_lhs[7] ^ w_res[7]);
                w_touch = 4'b1111;
            end
            OP_SBC: begin
                w_add   = {1'b0, bus.I_lhs} + {1'b0, ~bus.I_rhs} + (DATA_W+1)'(bus.I_carry);
                w_res   = w_add[DATA_W-1:0];
                w_c     = w_add[DATA_W];
                w_v     = (bus.I_lhs[7] ^ bus.I_rhs[7]) & (bus.I_lhs[7] ^ w_res[7]);
                w_touch = 4'b1111;
            end
            OP_AND: begin
                w_res   = bus.I_lhs & bus.I_rhs;
                w_touch = 4'b1010;
            end
            OP_ORA: begin
                w_res   = bus.I_lhs | bus.I_rhs;
                w_touch = 4'b1010;
            end
            OP_EOR: begin
                w_res   = bus.I_lhs ^ bus.I_rhs;
                w_touch = 4'b1010;
            end
            OP_CMP: begin
                w_add   = {1'b0, bus.I_lhs} - {1'b0, bus.I_rhs};
                w_res   = w_add[DATA_W-1:0];
                w_c     = (bus.I_lhs >= bus.I_rhs);
                w_touch = 4'b1011;
            end
            OP_BIT: begin
                w_res   = bus.I_lhs & bus.I_rhs;
                w_v     = bus.I_rhs[6];
                w_touch = 4'b1110;
            end
            OP_ASL: begin
                w_res   = {bus.I_lhs[6:0], 1'b0};
                w_c     = bus.I_lhs[7];
                w_touch = 4'b1011;
            end
            OP_LSR: begin
                w_res   = {1'b0, bus.I_lhs[7:1]};
                w_c     = bus.I_lhs[0];
                w_touch = 4'b1011;
            end
            OP_ROL: begin
                w_res   = {bus.I_lhs[6:0], bus.I_carry};
                w_c     = bus.I_lhs[7];
                w_touch = 4'b1011;
            end
            OP_ROR: begin
                w_res   = {bus.I_carry, bus.I_lhs[7:1]};
                w_c     = bus.I_lhs[0];
                w_touch = 4'b1011;
            end
            OP_INC: begin
                w_res   = bus.I_lhs + DATA_W'(1);
                w_touch = 4'b1010;
            end
            OP_DEC: begin
                w_res   = bus.I_lhs - DATA_W'(1);
                w_touch = 4'b1010;
            end
            OP_LD: begin
                w_res   = bus.I_rhs;
                w_touch = 4'b1010;
            end
            default: begin
                w_res   = bus.I_lhs;
                w_touch = '0;
            end
        endcase
    end

    // BIT reports the operand's bit 7 as N rather than the AND result
    always_comb begin
        w_n = w_res[7];
        w_z = (w_res == '0);
        if (bus.I_control == OP_BIT) begin
            w_n = bus.I_rhs[7];
        end
    end

    // Flags not defined by the op, or masked off, pass the incoming value through
    always_comb begin
        w_upd        = w_touch & bus.I_mask_p;
        w_flags[F_C] = w_upd[F_C] ? w_c : bus.I_carry;
        w_flags[F_Z] = w_upd[F_Z] ? w_z : bus.I_zero;
        w_flags[F_V] = w_upd[F_V] ? w_v : bus.I_overflow;
        w_flags[F_N] = w_upd[F_N] ? w_n : bus.I_sign;
    end

    assign bus.O_result   = w_res;
    assign bus.O_carry    = w_flags[F_C];
    assign bus.O_zero     = w_flags[F_Z];
    assign bus.O_overflow = w_flags[F_V];
    assign bus.O_sign     = w_flags[F_N];

    // Output register bank
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            r_result <= RESET_VALUE;
            r_flags  <= '0;
        end else if (bus.I_enable) begin
            r_result <= w_res;
            r_flags  <= w_flags;
        end
    end

    assign bus.Q_result = r_result;
    assign bus.Q_flags  = r_flags;

endmodule

// File: tb/tb_core_alu_reg.sv
// Directed-vector bench for core_alu_reg; a scoreboard queue carries expected
// combinational and registered values to a monitor sampling on the falling edge.
module tb_core_alu_reg;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    core_alu_reg_if u_if ();

    core_alu_reg #(.RESET_VALUE(8'h00)) u_dut (
        .I_clock (clk),
        .I_reset (rst_n),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         do_c;
        logic [7:0] c_res;
        logic [3:0] c_flg;
        bit         do_q;
        logic [7:0] q_res;
        logic [3:0] q_flg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    localparam logic [3:0] NOP = 4'd0,  ADC = 4'd1,  SBC = 4'd2,  ANDo = 4'd3;
    localparam logic [3:0] ORA = 4'd4,  EOR = 4'd5,  CMP = 4'd6,  BITo = 4'd7;
    localparam logic [3:0] ASL = 4'd8,  LSR = 4'd9,  ROL = 4'd10, ROR = 4'd11;
    localparam logic [3:0] INC = 4'd12, DEC = 4'd13, LD  = 4'd14, RSV = 4'd15;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.do_c) begin
                check({mon_e.name, ".O_result"}, u_if.O_result, mon_e.c_res);
                check({mon_e.name, ".O_flags"},
                      {4'h0, u_if.O_sign, u_if.O_overflow, u_if.O_zero, u_if.O_carry},
                      {4'h0, mon_e.c_flg});
            end
            if (mon_e.do_q) begin
                check({mon_e.name, ".Q_result"}, u_if.Q_result, mon_e.q_res);
                check({mon_e.name, ".Q_flags"}, {4'h0, u_if.Q_flags}, {4'h0, mon_e.q_flg});
            end
        end
    end

    // fin is the incoming {N,V,Z,C}; expectations are {N,V,Z,C}
    task automatic vec(input string nm, input logic rst, input logic en,
                       input logic [3:0] ctl, input logic [3:0] mask,
                       input logic [7:0] l, input logic [7:0] r, input logic [3:0] fin,
                       input bit do_c, input logic [7:0] cres, input logic [3:0] cflg,
                       input bit do_q, input logic [7:0] qres, input logic [3:0] qflg);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = rst;
        u_if.I_enable   = en;
        u_if.I_control  = ctl;
        u_if.I_mask_p   = mask;
        u_if.I_lhs      = l;
        u_if.I_rhs      = r;
        u_if.I_sign     = fin[3];
        u_if.I_overflow = fin[2];
        u_if.I_zero     = fin[1];
        u_if.I_carry    = fin[0];
        e.name  = nm;
        e.do_c  = do_c;
        e.c_res = cres;
        e.c_flg = cflg;
        e.do_q  = do_q;
        e.q_res = qres;
        e.q_flg = qflg;
        sb.push_back(e);
    endtask

    initial begin
        int waited;
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        u_if.I_enable = 1'b0; u_if.I_control = 4'h0; u_if.I_mask_p = 4'h0;
        u_if.I_lhs = 8'h00; u_if.I_rhs = 8'h00;
        u_if.I_carry = 1'b0; u_if.I_overflow = 1'b0; u_if.I_sign = 1'b0; u_if.I_zero = 1'b0;
        #1 rst_n = 1'b0;

        // Reset behaviour and first enabled load after release
        vec("rst",      0, 1, NOP, 4'hF, 8'h00, 8'h00, 4'b0000, 1, 8'h00, 4'b0000, 1, 8'h00, 4'h0);
        vec("rst_en",   0, 1, ADC, 4'hF, 8'h01, 8'h01, 4'b0000, 1, 8'h02, 4'b0000, 1, 8'h00, 4'h0);
        vec("release",  1, 1, ADC, 4'hF, 8'h01, 8'h01, 4'b0000, 1, 8'h02, 4'b0000, 1, 8'h00, 4'h0);

        // Combinational ops with enable low; Q must hold the first load
        vec("adc_ovf",  1, 0, ADC, 4'hF, 8'h50, 8'h50, 4'b0000, 1, 8'hA0, 4'b1100, 1, 8'h02, 4'h0);
        vec("adc_wrap", 1, 0, ADC, 4'hF, 8'hFF, 8'h01, 4'b0000, 1, 8'h00, 4'b0011, 1, 8'h02, 4'h0);
        vec("adc_cin",  1, 0, ADC, 4'hF, 8'h7F, 8'h00, 4'b0001, 1, 8'h80, 4'b1100, 1, 8'h02, 4'h0);
        vec("sbc_brw",  1, 0, SBC, 4'hF, 8'h50, 8'hF0, 4'b0001, 1, 8'h60, 4'b0000, 1, 8'h02, 4'h0);
        vec("sbc_ovf",  1, 0, SBC, 4'hF, 8'h80, 8'h01, 4'b0001, 1, 8'h7F, 4'b0101, 1, 8'h02, 4'h0);
        vec("cmp_eq",   1, 0, CMP, 4'hF, 8'h10, 8'h10, 4'b0100, 1, 8'h00, 4'b0111, 1, 8'h02, 4'h0);
        vec("cmp_lt",   1, 0, CMP, 4'hF, 8'h05, 8'h10, 4'b0000, 1, 8'hF5, 4'b1000, 1, 8'h02, 4'h0);
        vec("bit",      1, 0, BITo,4'hF, 8'h01, 8'hC0, 4'b0001, 1, 8'h00, 4'b1111, 1, 8'h02, 4'h0);
        vec("ror",      1, 0, ROR, 4'hF, 8'h01, 8'h00, 4'b0001, 1, 8'h80, 4'b1001, 1, 8'h02, 4'h0);
        vec("asl",      1, 0, ASL, 4'hF, 8'h80, 8'h00, 4'b0000, 1, 8'h00, 4'b0011, 1, 8'h02, 4'h0);
        vec("lsr",      1, 0, LSR, 4'hF, 8'h01, 8'h00, 4'b0000, 1, 8'h00, 4'b0011, 1, 8'h02, 4'h0);
        vec("rol",      1, 0, ROL, 4'hF, 8'h80, 8'h00, 4'b0001, 1, 8'h01, 4'b0001, 1, 8'h02, 4'h0);
        vec("inc_wrap", 1, 0, INC, 4'hF, 8'hFF, 8'h00, 4'b1001, 1, 8'h00, 4'b0011, 1, 8'h02, 4'h0);
        vec("dec_wrap", 1, 0, DEC, 4'hF, 8'h00, 8'h00, 4'b0000, 1, 8'hFF, 4'b1000, 1, 8'h02, 4'h0);
        vec("and",      1, 0, ANDo,4'hF, 8'hF0, 8'h3C, 4'b0101, 1, 8'h30, 4'b0101, 1, 8'h02, 4'h0);
        vec("ora",      1, 0, ORA, 4'hF, 8'h80, 8'h01, 4'b0000, 1, 8'h81, 4'b1000, 1, 8'h02, 4'h0);
        vec("eor",      1, 0, EOR, 4'hF, 8'hAA, 8'hAA, 4'b0001, 1, 8'h00, 4'b0011, 1, 8'h02, 4'h0);
        vec("ld",       1, 0, LD,  4'hF, 8'h00, 8'h80, 4'b0010, 1, 8'h80, 4'b1000, 1, 8'h02, 4'h0);
        vec("nop",      1, 0, NOP, 4'hF, 8'h5A, 8'h33, 4'b1011, 1, 8'h5A, 4'b1011, 1, 8'h02, 4'h0);
        vec("rsv",      1, 0, RSV, 4'hF, 8'h00, 8'hFF, 4'b0000, 1, 8'h00, 4'b0000, 1, 8'h02, 4'h0);
        vec("mask_z",   1, 0, ADC, 4'h2, 8'hFF, 8'h01, 4'b1100, 1, 8'h00, 4'b1110, 1, 8'h02, 4'h0);
        vec("mask_0",   1, 0, ADC, 4'h0, 8'h50, 8'h50, 4'b0110, 1, 8'hA0, 4'b0110, 1, 8'h02, 4'h0);

        // Second load, hold, then reset asserted between edges
        vec("load2",    1, 1, DEC, 4'hF, 8'h00, 8'h00, 4'b0000, 1, 8'hFF, 4'b1000, 1, 8'h02, 4'h0);
        vec("hold2",    1, 0, INC, 4'hF, 8'h10, 8'h00, 4'b0000, 1, 8'h11, 4'b0000, 1, 8'hFF, 4'h8);
        vec("hold3",    1, 0, NOP, 4'hF, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 4'b0000, 1, 8'hFF, 4'h8);
        vec("mid_rst",  0, 1, ADC, 4'hF, 8'h01, 8'h01, 4'b0000, 1, 8'h02, 4'b0000, 1, 8'h00, 4'h0);
        vec("post_rst", 1, 0, NOP, 4'hF, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 4'b0000, 1, 8'h00, 4'h0);

        waited = 0;
        while (sb.size() > 0 && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
